// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one async-FIFO write port among
//               NUM_REQ producers with bounded bursts; never writes while full.
//               Optional stall statistics: FIFO_WR_ARB_STALL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          w_clk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          w_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          w_inc,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(NUM_REQ)-1:0]    owner_id,
  output logic                          busy,
  output logic [15:0]                   stall_cnt
);

  localparam int             IDW         = $clog2(NUM_REQ);
  localparam logic [3:0]     C_LAST_BEAT = 4'(BURST_MAX - 1);
  localparam logic [IDW-1:0] C_LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDW-1:0]          r_rr_ptr;
  logic [IDW-1:0]          r_owner;
  logic [IDW-1:0]          w_rr_nxt;
  logic [IDW-1:0]          w_owner_nxt;
  logic [IDW-1:0]          w_rr_after;
  logic [IDW-1:0]          w_pick;
  logic [IDW-1:0]          w_cand;
  logic                    w_found;
  logic [3:0]              r_beat_cnt;
  logic [3:0]              w_beat_nxt;
  logic                    w_owner_req;
  logic [DATA_WIDTH-1:0]   w_slice [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign gnt[gi]     = w_inc && (r_owner == IDW'(gi));
    end
  endgenerate

  // Reset gates the write strobe combinationally so the reset-cycle beat is lost.
  assign w_owner_req = req[r_owner];
  assign w_inc       = (r_state == S_BURST) && w_owner_req && !w_full && !wrst_n;
  assign w_data      = w_slice[r_owner];
  assign owner_id    = r_owner;
  assign busy        = (r_state == S_BURST);
  assign w_rr_after  = (r_owner == C_LAST_ID) ? '0 : r_owner + IDW'(1);

  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_cand  = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
      w_cand = (w_cand == C_LAST_ID) ? '0 : w_cand + IDW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_beat_nxt  = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_owner_nxt = w_pick;
          w_beat_nxt  = 4'd0;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (!w_owner_req) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = w_rr_after;
        end else if (w_inc) begin
          w_beat_nxt = r_beat_cnt + 4'd1;
          if (r_beat_cnt == C_LAST_BEAT) begin
            w_state_nxt = S_IDLE;
            w_rr_nxt    = w_rr_after;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (wrst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

`ifdef FIFO_WR_ARB_STALL_STATS_EN
  logic        w_stall;
  logic [15:0] r_stall_cnt;

  assign w_stall   = (r_state == S_BURST) && w_owner_req && w_full;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge w_clk) begin
    if (wrst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int IW = 2;

  logic            w_clk = 1'b0;
  logic            wrst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            w_full;
  logic [N-1:0]    gnt;
  logic            w_inc;
  logic [DW-1:0]   w_data;
  logic [IW-1:0]   owner_id;
  logic            busy;
  logic [15:0]     stall_cnt;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .w_clk(w_clk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .w_full(w_full), .gnt(gnt), .w_inc(w_inc), .w_data(w_data),
    .owner_id(owner_id), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 w_clk = ~w_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: m_owner = -1 means no burst in progress.
  int              m_owner = -1;
  int              m_oid   = 0;
  int              m_beats = 0;
  int              m_rr    = 0;
  int              m_stall = 0;
  logic            p_rst   = 1'b1;
  logic [N-1:0]    p_req   = '0;
  logic            p_full  = 1'b0;
  logic [N*DW-1:0] p_data  = '0;
  logic [31:0]     exp_v;

  function automatic void model_advance();
    int c;
    if (p_rst) begin
      m_owner = -1; m_oid = 0; m_beats = 0; m_rr = 0; m_stall = 0;
    end else if (m_owner < 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        c = (m_rr + k) % N;
        if (p_req[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_oid = m_owner;
        m_beats = 0;
      end
    end else if (!p_req[m_owner]) begin
      m_rr = (m_owner + 1) % N;
      m_owner = -1;
    end else if (p_full) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      m_beats++;
      if (m_beats == BM) begin
        m_rr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endfunction

  function automatic void model_expect();
    logic         e_inc;
    logic [N-1:0] e_gnt;
    logic [15:0]  e_stall;
    logic [DW-1:0] e_data;
    e_inc = !p_rst && (m_owner >= 0) && p_req[m_owner] && !p_full;
    e_gnt = '0;
    if (e_inc) e_gnt[m_owner] = 1'b1;
`ifdef FIFO_WR_ARB_STALL_STATS_EN
    e_stall = 16'(m_stall);
`else
    e_stall = 16'h0000;
`endif
    e_data = (m_owner >= 0) ? p_data[m_oid*DW +: DW] : '0;
    exp_v = {e_inc, e_gnt, (m_owner >= 0), IW'(m_oid), e_stall, e_data};
  endfunction

  function automatic logic [31:0] observed();
    return {w_inc, gnt, busy, owner_id, stall_cnt, (m_owner >= 0) ? w_data : 8'h00};
  endfunction

  // One clock: registers advance, new inputs applied, expectation formed mid-cycle.
  task automatic drive(input logic r, input logic [N-1:0] rq, input logic f,
                       input logic [N*DW-1:0] d);
    @(posedge w_clk);
    model_advance();
    #1;
    wrst_n = r; req = rq; w_full = f; req_data = d;
    p_rst = r; p_req = rq; p_full = f; p_data = d;
    #2;
    model_expect();
  endtask

  function automatic logic [N*DW-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b1111, 1'b0, rand_data());
      n_cmp++;
      if ({w_inc, gnt, busy, owner_id, stall_cnt} !== 24'h0) begin
        n_err++;
        $display("FAIL reset cyc%0d: got inc=%b gnt=%b busy=%b owner=%0d stall=%0d, want all 0",
                 i, w_inc, gnt, busy, owner_id, stall_cnt);
      end
    end
  endtask

  task automatic test_single();
    int beats = 0;
    drive(1'b1, 4'b0000, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'b0100, 1'b0, 32'h00A5_0000);
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++;
        $display("FAIL single cyc%0d: got %h want %h", i, observed(), exp_v);
      end
      if (w_inc && gnt == 4'b0100 && w_data == 8'hA5) beats++;
    end
    n_cmp++;
    if (beats !== 8) begin
      n_err++;
      $display("FAIL single_beats: got %0d want 8", beats);
    end
  endtask

  task automatic test_round_robin();
    int   owners[$];
    int   beats = 0;
    logic was_busy = 1'b0;
    drive(1'b1, 4'b0000, 1'b0, '0);
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 4'b1111, 1'b0, rand_data());
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++;
        $display("FAIL rr cyc%0d: got %h want %h", i, observed(), exp_v);
      end
      if (busy && !was_busy) owners.push_back(int'(owner_id));
      was_busy = busy;
      if (w_inc) beats++;
    end
    n_cmp++;
    if (owners.size() != 5 || owners[0] != 0 || owners[1] != 1 || owners[2] != 2 ||
        owners[3] != 3 || owners[4] != 0 || beats != 20) begin
      n_err++;
      $display("FAIL rr_order: got %0d bursts, %0d beats, want owners 0,1,2,3,0 and 20 beats",
               owners.size(), beats);
    end
  endtask

  task automatic test_full_stall();
    logic f;
    drive(1'b1, 4'b0000, 1'b0, '0);
    for (int i = 1; i <= 11; i++) begin
      f = (i >= 4 && i <= 8);
      drive(1'b0, 4'b0010, f, rand_data());
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++;
        $display("FAIL stall cyc%0d: got %h want %h", i, observed(), exp_v);
      end
      if (f) begin
        n_cmp++;
        if (w_inc !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1 || owner_id !== 2'd1) begin
          n_err++;
          $display("FAIL stall_hold cyc%0d: got inc=%b gnt=%b busy=%b owner=%0d, want 0/0000/1/1",
                   i, w_inc, gnt, busy, owner_id);
        end
      end
      if (i == 9 || i == 10) begin
        n_cmp++;
        if (w_inc !== 1'b1 || gnt !== 4'b0010) begin
          n_err++;
          $display("FAIL stall_resume cyc%0d: got inc=%b gnt=%b want 1/0010", i, w_inc, gnt);
        end
      end
    end
    n_cmp++;
`ifdef FIFO_WR_ARB_STALL_STATS_EN
    if (stall_cnt !== 16'd5 || busy !== 1'b0) begin
`else
    if (stall_cnt !== 16'd0 || busy !== 1'b0) begin
`endif
      n_err++;
      $display("FAIL stall_count: got stall=%0d busy=%b", stall_cnt, busy);
    end
  endtask

  task automatic test_withdraw();
    logic [N-1:0] pat [5] = '{4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1000};
    drive(1'b1, 4'b0000, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, pat[i], 1'b0, rand_data());
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++;
        $display("FAIL withdraw cyc%0d: got %h want %h", i, observed(), exp_v);
      end
    end
    n_cmp++;
    if (owner_id !== 2'd3 || w_inc !== 1'b1 || gnt !== 4'b1000) begin
      n_err++;
      $display("FAIL withdraw_next: got owner=%0d inc=%b gnt=%b want 3/1/1000",
               owner_id, w_inc, gnt);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'b0000, 1'b0, '0);
    drive(1'b0, 4'b0001, 1'b0, rand_data());
    drive(1'b0, 4'b0001, 1'b0, rand_data());
    drive(1'b1, 4'b0001, 1'b0, rand_data());
    n_cmp++;
    if (w_inc !== 1'b0 || gnt !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_beat: got inc=%b gnt=%b want 0/0000", w_inc, gnt);
    end
    drive(1'b0, 4'b0011, 1'b0, rand_data());
    n_cmp++;
    if (busy !== 1'b0 || owner_id !== 2'd0 || stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_mid_idle: got busy=%b owner=%0d stall=%0d want 0/0/0",
               busy, owner_id, stall_cnt);
    end
    drive(1'b0, 4'b0011, 1'b0, rand_data());
    n_cmp++;
    if (owner_id !== 2'd0 || w_inc !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_rr: got owner=%0d inc=%b want 0/1", owner_id, w_inc);
    end
  endtask

  task automatic test_random();
    logic r;
    logic f;
    drive(1'b1, 4'b0000, 1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 25);
      drive(r, N'($urandom), f, rand_data());
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++;
        $display("FAIL random cyc%0d: got %h want %h", i, observed(), exp_v);
      end
    end
  endtask

  initial begin
    wrst_n = 1'b1; req = '0; w_full = 1'b0; req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter sharing one async-FIFO write side (binary/Gray write pointer with registered full flag) among NUM_REQ producers in the w_clk domain.
- Grants one requester at a time for a bounded burst.
- Drives w_inc and w_data into the FIFO write logic.
- Never asserts w_inc while w_full is high, so no beat is silently dropped.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, FIFO data word width
- BURST_MAX, 4, max beats per grant before re-arbitration (1..15)

Ports:
- w_clk  input  1  write-domain clock
- wrst_n  input  1  synchronous reset, active-high (reset when 1), sampled on posedge w_clk
- req  input  NUM_REQ  per-requester write request; held with data until accepted
- req_data  input  NUM_REQ*DATA_WIDTH  packed data, slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- w_full  input  1  FIFO full flag (registered, from write-pointer block)
- gnt  output  NUM_REQ  one-hot accept pulse; beat of requester i consumed this cycle
- w_inc  output  1  FIFO write enable
- w_data  output  DATA_WIDTH  FIFO write data
- owner_id  output  $clog2(NUM_REQ)  current burst owner (valid in BURST)
- busy  output  1  high in BURST state
- stall_cnt  output  16  full-stall cycle counter (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, owner_id=0, beat_cnt=0, busy=0, stall_cnt=0.
- Reset has priority over all other activity.
- Reset mid-burst aborts the burst. The beat in the reset cycle is not written: w_inc=0 combinationally whenever wrst_n=1.
- Two states: IDLE and BURST.
- IDLE:
  - w_inc=0, gnt=0.
  - If any req bit is set: owner_id <= first set bit searching from rr_ptr upward, with wrap; beat_cnt <= 0; go to BURST.
  - Arbitration costs exactly one cycle; no beat is accepted in IDLE.
- BURST, combinational outputs:
  - w_inc = req[owner_id] & ~w_full
  - gnt[owner_id] = w_inc; all other gnt bits 0
  - w_data = req_data slice of owner_id (driven regardless of w_inc)
- BURST, on each beat (w_inc=1): beat_cnt increments.
- BURST exit to IDLE, with rr_ptr <= owner_id+1 mod NUM_REQ:
  - a beat occurs with beat_cnt == BURST_MAX-1, or
  - req[owner_id]==0 (owner withdrew); no beat that cycle.
- BURST with w_full=1 and req[owner_id]=1: hold state; no beat; beat_cnt unchanged; stall (see Optional Feature).
- Requests from non-owners are ignored during BURST; they are served after the burst ends, in round-robin order.
- Simultaneous beat at BURST_MAX-1 and new requests: exit to IDLE; the next owner is picked next cycle, searching from the updated rr_ptr.
- Fairness: the last owner has lowest priority in the next arbitration.
- Worst-case wait for a requester with w_full=0: (NUM_REQ-1)*(BURST_MAX+1) cycles.
- Width rules: beat_cnt is 4 bits; rr_ptr and owner_id are $clog2(NUM_REQ) bits, wrapping modulo NUM_REQ (explicit compare, not a natural wrap, for non-power-of-2 NUM_REQ).
- No FIFO pointer state is kept here; full/empty is owned by the pointer blocks.

Optional Feature:
- Macro: FIFO_WR_ARB_STALL_STATS_EN
- Defined:
  - stall_cnt increments on every cycle in BURST with req[owner_id]=1 and w_full=1.
  - Saturates at 16'hFFFF.
  - Clears only on reset.
- Undefined: stall_cnt is tied to 16'h0000 and no counter logic is built.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: wrst_n=1 for 2 cycles with req=4'b1111 -> w_inc=0, gnt=0, busy=0, owner_id=0, stall_cnt=0.
- Single requester, req=4'b0100 held, data 8'hA5, w_full=0 -> one IDLE cycle, then 4 consecutive gnt=4'b0100 with w_inc=1 and w_data=8'hA5, then 1 IDLE cycle, repeating.
- Round-robin: req=4'b1111 held -> owners 0,1,2,3,0 in order, 4 beats each, separated by one IDLE cycle.
- Full stall: owner 1 mid-burst after 2 beats, w_full=1 for 5 cycles -> w_inc=0 and gnt=0 for those 5 cycles; busy=1; burst then completes remaining 2 beats; stall_cnt=5 with macro defined, 0 without.
- Withdrawal: owner 2 drops req after 1 beat, req[3]=1 -> exit to IDLE; next owner=3; rr_ptr=3.
- Reset mid-burst: wrst_n=1 during owner 0 beat 2 -> no w_inc that cycle; next cycle state=IDLE, rr_ptr=0, stall_cnt=0.
